// File: rtl/sha512_stream_padder.sv
// rtl/sha512_stream_padder.sv - SHA-512 streaming message padder: 64-bit words in, padded 1024-bit blocks out
module sha512_stream_padder #(
    parameter int LEN_W = 128
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          i_valid,
    output logic          i_ready,
    input  logic [63:0]   i_data,
    input  logic          i_last,
    input  logic [3:0]    i_nbytes,
    output logic          o_valid,
    input  logic          o_ready,
    output logic [1023:0] o_block,
    output logic          o_last,
    output logic          busy
);

    localparam logic [63:0] PAD_WORD = 64'h8000_0000_0000_0000;

    typedef enum logic [1:0] {
        S_FILL,
        S_PAD,
        S_EMIT
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [4:0]       wptr;
    logic [63:0]      words [16];
    logic [LEN_W-1:0] len;
    logic             pend80;
    logic             pad_pend;

    logic [127:0]     len128;
    logic [3:0]       n_clamp;
    logic [7:0]       len_inc;
    logic [63:0]      last_word;
    logic             in_fire;
    logic             room;
    logic             len_now;

    assign n_clamp = (i_nbytes > 4'd8) ? 4'd8 : i_nbytes;
    assign in_fire = i_valid && i_ready;
    assign room    = !pend80 && (wptr <= 5'd14);
    assign len_now = room && (wptr == 5'd14);
    assign len128  = 128'(len);
    assign len_inc = i_last ? {1'b0, n_clamp, 3'b000} : 8'd64;

    // Final word: keep the counted bytes, drop the rest, and place the 0x80 marker right after them
    always_comb begin
        last_word = '0;
        for (int b = 0; b < 8; b++) begin
            if (4'(b) < n_clamp) begin
                last_word[63-8*b -: 8] = i_data[63-8*b -: 8];
            end else if (4'(b) == n_clamp) begin
                last_word[63-8*b -: 8] = 8'h80;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 16; k++) begin
            o_block[1023-64*k -: 64] = words[k];
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= S_FILL;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        i_ready  = 1'b0;
        o_valid  = 1'b0;
        busy     = !((state == S_FILL) && (wptr == 5'd0) && (len == '0));
        case (state)
            S_FILL: begin
                i_ready = n_rst && (wptr < 5'd16);
                if (in_fire && (i_last || (wptr == 5'd15))) begin
                    state_nx = (wptr == 5'd15) ? S_EMIT : S_PAD;
                end
            end
            S_PAD: begin
                // Every PAD step at word 14 or 15 completes the current block
                if (wptr >= 5'd14) begin
                    state_nx = S_EMIT;
                end
            end
            S_EMIT: begin
                o_valid = 1'b1;
                if (o_ready) begin
                    state_nx = pad_pend ? S_PAD : S_FILL;
                end
            end
            default: state_nx = S_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int k = 0; k < 16; k++) begin
                words[k] <= '0;
            end
            wptr     <= '0;
            len      <= '0;
            pend80   <= 1'b0;
            pad_pend <= 1'b0;
            o_last   <= 1'b0;
        end else begin
            case (state)
                S_FILL: begin
                    if (in_fire) begin
                        words[wptr[3:0]] <= i_last ? last_word : i_data;
                        wptr             <= wptr + 5'd1;
                        len              <= len + LEN_W'(len_inc);
                        if (i_last) begin
                            pend80   <= (n_clamp == 4'd8);
                            pad_pend <= (wptr == 5'd15);
                        end
                    end
                end
                S_PAD: begin
                    if (len_now) begin
                        words[14] <= len128[127:64];
                        words[15] <= len128[63:0];
                        wptr      <= 5'd16;
                        o_last    <= 1'b1;
                    end else begin
                        words[wptr[3:0]] <= pend80 ? PAD_WORD : 64'd0;
                        pend80           <= 1'b0;
                        // No room left for the length: close this block and schedule a padding-only one
                        if (wptr == 5'd14) begin
                            words[15] <= '0;
                            wptr      <= 5'd16;
                            pad_pend  <= 1'b1;
                        end else if (wptr == 5'd15) begin
                            wptr     <= 5'd16;
                            pad_pend <= 1'b1;
                        end else begin
                            wptr <= wptr + 5'd1;
                        end
                    end
                end
                S_EMIT: begin
                    if (o_ready) begin
                        wptr     <= '0;
                        o_last   <= 1'b0;
                        pad_pend <= 1'b0;
                        if (o_last) begin
                            len <= '0;
                        end
                    end
                end
                default: begin
                    wptr <= '0;
                end
            endcase
        end
    end

endmodule
